// File: rtl/mult_ctrl_fsm_if.sv
// Handshake and strobe bundle between the multiplier controller, the
// shift-and-add datapath and the surrounding system.
interface mult_ctrl_fsm_if;
  logic i_start;
  logic A_out;
  logic load_A;
  logic load_B;
  logic clr_ACC_reg;
  logic load_ACC;
  logic shift_A_reg;
  logic sel_SUM;
  logic Lsb_out;
  logic Msb_out;
  logic o_busy;
  logic o_done;
  logic o_req_b;

  modport master (
    input  i_start, A_out,
    output load_A, load_B, clr_ACC_reg, load_ACC, shift_A_reg, sel_SUM,
           Lsb_out, Msb_out, o_busy, o_done, o_req_b
  );

  modport slave (
    output i_start, A_out,
    input  load_A, load_B, clr_ACC_reg, load_ACC, shift_A_reg, sel_SUM,
           Lsb_out, Msb_out, o_busy, o_done, o_req_b
  );
endinterface

// File: rtl/mult_ctrl_fsm.sv
// Sequencer for the 8-bit shift-and-add multiplier: operand capture,
// WIDTH add/shift iterations, then low/high result byte readout.
module mult_ctrl_fsm #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  mult_ctrl_fsm_if.master  ctl
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_B = 3'd1,
    CALC   = 3'd2,
    OUT_LO = 3'd3,
    OUT_HI = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  // Low during reset and the first cycle after release, so a start held
  // across reset cannot leak a load_A strobe in that window.
  logic             armed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    ctl.load_A      = 1'b0;
    ctl.load_B      = 1'b0;
    ctl.clr_ACC_reg = 1'b0;
    ctl.load_ACC    = 1'b0;
    ctl.shift_A_reg = 1'b0;
    ctl.sel_SUM     = 1'b0;
    ctl.Lsb_out     = 1'b0;
    ctl.Msb_out     = 1'b0;
    ctl.o_busy      = 1'b1;
    ctl.o_done      = 1'b0;
    ctl.o_req_b     = 1'b0;

    case (state)
      IDLE: begin
        ctl.o_busy = 1'b0;
        ctl.load_A = ctl.i_start & armed;
        if (ctl.i_start && armed) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        ctl.load_B      = 1'b1;
        ctl.clr_ACC_reg = 1'b1;
        ctl.o_req_b     = 1'b1;
        cnt_nxt         = '0;
        state_nxt       = CALC;
      end
      CALC: begin
        ctl.load_ACC    = 1'b1;
        ctl.shift_A_reg = 1'b1;
        ctl.sel_SUM     = ctl.A_out;
        cnt_nxt         = cnt + CNT_W'(1);
        if (cnt == LAST_ITER) state_nxt = OUT_LO;
      end
      OUT_LO: begin
        ctl.Lsb_out = 1'b1;
        state_nxt   = OUT_HI;
      end
      OUT_HI: begin
        ctl.Msb_out = 1'b1;
        ctl.o_done  = 1'b1;
        state_nxt   = IDLE;
      end
      default: begin
        ctl.o_busy = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

endmodule
